// File: rtl/hand_hit_tracker.sv
// Per-hand zone debounce with hit events queued in a show-ahead FIFO.
// Optional HIT_SWIPE_EN adds swipe-left/right events on adjacent-column moves.

module hand_hit_lane #(
    parameter int NX            = 8,
    parameter int ZBW           = 6,
    parameter int STABLE_FRAMES = 3,
    parameter int IGNORE_ZONE0  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           frame_done,
    input  logic [ZBW-1:0] zone,
    output logic           ev_valid,
    output logic [ZBW-1:0] ev_zone,
    output logic [1:0]     ev_kind
);
    localparam int CW = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW:0] SF = (CW + 1)'(STABLE_FRAMES);

    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

    state_t         state, state_nx;
    logic [ZBW-1:0] cur_zone, cur_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [CW:0]    cnt_inc;
    logic           absent, same, reach;

    assign absent  = (IGNORE_ZONE0 != 0) && (zone == '0);
    assign same    = (zone == cur_zone);
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    // >= keeps STABLE_FRAMES==1 working after a HELD->TRACK move
    assign reach   = (cnt_inc >= SF);

`ifdef HIT_SWIPE_EN
    localparam logic [ZBW:0] NXW = (ZBW + 1)'(NX);
    logic [ZBW:0] row_z, row_c, col_z, col_c;
    logic         swipe_l, swipe_r;
    assign row_z   = {1'b0, zone} / NXW;
    assign row_c   = {1'b0, cur_zone} / NXW;
    assign col_z   = {1'b0, zone} % NXW;
    assign col_c   = {1'b0, cur_zone} % NXW;
    assign swipe_l = (row_z == row_c) && (col_z + 1'b1 == col_c);
    assign swipe_r = (row_z == row_c) && (col_c + 1'b1 == col_z);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_zone <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            cur_zone <= cur_nx;
            cnt      <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cur_nx   = cur_zone;
        cnt_nx   = cnt;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (frame_done) begin
            if (absent) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                case (state)
                    IDLE: begin
                        cur_nx   = zone;
                        cnt_nx   = CW'(1);
                        state_nx = (STABLE_FRAMES == 1) ? HELD : TRACK;
                    end
                    TRACK: begin
                        if (same) begin
                            cnt_nx = reach ? SF[CW-1:0] : cnt_inc[CW-1:0];
                            if (reach) state_nx = HELD;
                        end else begin
                            cur_nx = zone;
                            cnt_nx = CW'(1);
                        end
                    end
                    HELD: begin
                        if (!same) begin
                            cur_nx   = zone;
                            cnt_nx   = CW'(1);
                            state_nx = TRACK;
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ev_valid = 1'b0;
        ev_zone  = zone;
        ev_kind  = 2'b00;
        if (enable && frame_done && !absent) begin
            case (state)
                IDLE:  ev_valid = (STABLE_FRAMES == 1);
                TRACK: ev_valid = same && reach;
`ifdef HIT_SWIPE_EN
                HELD: begin
                    ev_valid = !same && (swipe_l || swipe_r);
                    ev_kind  = swipe_l ? 2'b01 : 2'b10;
                end
`endif
                default: ev_valid = 1'b0;
            endcase
        end
    end
endmodule

module hand_hit_tracker #(
    parameter int NX            = 8,
    parameter int NY            = 6,
    parameter int ZBW           = $clog2(NX * NY),
    parameter int STABLE_FRAMES = 3,
    parameter int IGNORE_ZONE0  = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          frame_done,
    input  logic [ZBW-1:0]                blue_zone,
    input  logic [ZBW-1:0]                red_zone,
    output logic                          hit_valid,
    input  logic                          hit_ready,
    output logic                          hit_hand,
    output logic [ZBW-1:0]                hit_zone,
    output logic [1:0]                    hit_kind,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic           hand;
        logic [ZBW-1:0] zone;
        logic [1:0]     kind;
    } hit_ev_t;

    logic [1:0][ZBW-1:0] zin, ev_zone, pend_zone;
    logic [1:0][1:0]     ev_kind, pend_kind;
    logic [1:0]          ev_valid, pend_vld, taken, collide;

    assign zin = {red_zone, blue_zone};

    for (genvar h = 0; h < 2; h++) begin : g_lane
        hand_hit_lane #(
            .NX(NX), .ZBW(ZBW), .STABLE_FRAMES(STABLE_FRAMES), .IGNORE_ZONE0(IGNORE_ZONE0)
        ) u_lane (
            .clk(clk), .reset_n(reset_n), .enable(enable), .frame_done(frame_done),
            .zone(zin[h]), .ev_valid(ev_valid[h]), .ev_zone(ev_zone[h]), .ev_kind(ev_kind[h])
        );
    end

    hit_ev_t        mem [FIFO_DEPTH];
    hit_ev_t        wr_ev, head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           wr_req, full, pop, push, drop;

    // Blue wins the single FIFO write port; red waits one edge
    assign taken[0] = pend_vld[0];
    assign taken[1] = pend_vld[1] & ~pend_vld[0];
    assign wr_req   = |pend_vld;
    assign wr_ev    = pend_vld[0] ? hit_ev_t'{1'b0, pend_zone[0], pend_kind[0]}
                                  : hit_ev_t'{1'b1, pend_zone[1], pend_kind[1]};
    assign full     = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign pop      = hit_valid && hit_ready;
    assign push     = wr_req && (!full || pop);
    assign drop     = wr_req && full && !pop;
    assign collide  = ev_valid & pend_vld & ~taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld  <= '0;
            pend_zone <= '0;
            pend_kind <= '0;
            overflow  <= 1'b0;
        end else begin
            for (int h = 0; h < 2; h++) begin
                if (ev_valid[h]) begin
                    pend_vld[h]  <= 1'b1;
                    pend_zone[h] <= ev_zone[h];
                    pend_kind[h] <= ev_kind[h];
                end else if (taken[h]) begin
                    pend_vld[h]  <= 1'b0;
                end
            end
            if (drop || (|collide)) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_ev;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign hit_valid = (fifo_level != '0);
    assign hit_hand  = hit_valid & head.hand;
    assign hit_zone  = hit_valid ? head.zone : '0;
    assign hit_kind  = hit_valid ? head.kind : 2'b00;
endmodule

// File: tb/tb_hand_hit_tracker.sv
// Directed bench for hand_hit_tracker: frame table with level/overflow checks plus corner sequences.

module tb_hand_hit_tracker;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       frame_done = 1'b0;
    logic [5:0] blue_zone = '0;
    logic [5:0] red_zone = '0;
    logic       hit_ready = 1'b0;
    logic       hit_valid, hit_hand, overflow;
    logic [5:0] hit_zone;
    logic [1:0] hit_kind;
    logic [2:0] fifo_level;

    int total = 0;
    int bad = 0;

    hand_hit_tracker dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_done(frame_done),
        .blue_zone(blue_zone), .red_zone(red_zone), .hit_valid(hit_valid),
        .hit_ready(hit_ready), .hit_hand(hit_hand), .hit_zone(hit_zone),
        .hit_kind(hit_kind), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [5:0] b;
        logic [5:0] r;
        int         lvl;
        int         ovf;
    } vec_t;

    typedef struct {
        int hand;
        int zone;
    } exp_ev_t;

    vec_t    tbl [19];
    exp_ev_t drain [4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; the frame is sampled on the next edge
    task automatic frame(input logic en, input logic [5:0] b, input logic [5:0] r);
        enable = en; blue_zone = b; red_zone = r; frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pop_one();
        hit_ready = 1'b1;
        @(posedge clk); #1;
        hit_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 6'd10, 6'd0,  0, 0};
        tbl[1]  = '{1'b1, 6'd10, 6'd0,  0, 0};
        tbl[2]  = '{1'b1, 6'd10, 6'd0,  1, 0};
        tbl[3]  = '{1'b1, 6'd10, 6'd0,  1, 0};
        tbl[4]  = '{1'b1, 6'd10, 6'd0,  1, 0};
        tbl[5]  = '{1'b1, 6'd12, 6'd20, 1, 0};
        tbl[6]  = '{1'b1, 6'd12, 6'd20, 1, 0};
        tbl[7]  = '{1'b1, 6'd12, 6'd20, 3, 0};
        tbl[8]  = '{1'b1, 6'd5,  6'd20, 3, 0};
        tbl[9]  = '{1'b1, 6'd5,  6'd20, 3, 0};
        tbl[10] = '{1'b1, 6'd6,  6'd20, 3, 0};
        tbl[11] = '{1'b1, 6'd6,  6'd20, 3, 0};
        tbl[12] = '{1'b1, 6'd6,  6'd20, 4, 0};
        tbl[13] = '{1'b0, 6'd7,  6'd7,  4, 0};
        tbl[14] = '{1'b0, 6'd7,  6'd7,  4, 0};
        tbl[15] = '{1'b0, 6'd7,  6'd7,  4, 0};
        tbl[16] = '{1'b1, 6'd7,  6'd0,  4, 0};
        tbl[17] = '{1'b1, 6'd7,  6'd0,  4, 0};
        tbl[18] = '{1'b1, 6'd7,  6'd0,  4, 1};
        drain[0] = '{0, 10};
        drain[1] = '{0, 12};
        drain[2] = '{1, 20};
        drain[3] = '{0, 6};

        // Reset values
        idle(2);
        chk("rst_valid", hit_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_hand", hit_hand, 0);
        chk("rst_zone", hit_zone, 0);
        chk("rst_kind", hit_kind, 0);
        reset_n = 1'b1;
        idle(1);

        // Frame table with the consumer stalled
        for (int i = 0; i < 19; i++) begin
            frame(tbl[i].en, tbl[i].b, tbl[i].r);
            idle(2);
            chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
            chk($sformatf("tbl%0d_valid", i), hit_valid, (tbl[i].lvl != 0) ? 1 : 0);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), hit_valid, 1);
            chk($sformatf("drain%0d_hand", i), hit_hand, drain[i].hand);
            chk($sformatf("drain%0d_zone", i), hit_zone, drain[i].zone);
            chk($sformatf("drain%0d_kind", i), hit_kind, 0);
            pop_one();
        end
        chk("drain_empty_valid", hit_valid, 0);
        chk("drain_empty_level", fifo_level, 0);
        chk("drain_ovf_sticky", overflow, 1);

        // Latency: hit_valid one edge after the 3rd frame; then async reset clears it
        do_reset();
        frame(1'b1, 6'd10, 6'd0); idle(1);
        frame(1'b1, 6'd10, 6'd0); idle(1);
        frame(1'b1, 6'd10, 6'd0);
        chk("lat_e0_valid", hit_valid, 0);
        idle(1);
        chk("lat_e1_valid", hit_valid, 1);
        chk("lat_e1_zone", hit_zone, 10);
        for (int i = 0; i < 5; i++) begin
            frame(1'b1, 6'd10, 6'd0); idle(1);
        end
        chk("held_no_more_level", fifo_level, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", hit_valid, 0);
        chk("async_rst_level", fifo_level, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);

        // Blue and red in the same frame: blue at E0+1, red at E0+2
        enable = 1'b1;
        frame(1'b1, 6'd12, 6'd20); idle(1);
        frame(1'b1, 6'd12, 6'd20); idle(1);
        frame(1'b1, 6'd12, 6'd20);
        chk("dual_e0_level", fifo_level, 0);
        idle(1);
        chk("dual_e1_level", fifo_level, 1);
        chk("dual_e1_hand", hit_hand, 0);
        chk("dual_e1_zone", hit_zone, 12);
        idle(1);
        chk("dual_e2_level", fifo_level, 2);
        pop_one();
        chk("dual_2nd_hand", hit_hand, 1);
        chk("dual_2nd_zone", hit_zone, 20);

        // 5,5,0,5,5,5 hits only on the 6th frame
        do_reset();
        frame(1'b1, 6'd5, 6'd0); idle(1);
        frame(1'b1, 6'd5, 6'd0); idle(1);
        frame(1'b1, 6'd0, 6'd0); idle(1);
        frame(1'b1, 6'd5, 6'd0); idle(1);
        frame(1'b1, 6'd5, 6'd0); idle(1);
        chk("absent_before_level", fifo_level, 0);
        frame(1'b1, 6'd5, 6'd0); idle(1);
        chk("absent_after_level", fifo_level, 1);
        chk("absent_after_zone", hit_zone, 5);

        // Held on 9, move to 10 (same row, col+1)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            frame(1'b1, 6'd9, 6'd0); idle(1);
        end
        chk("held9_zone", hit_zone, 9);
        pop_one();
        frame(1'b1, 6'd10, 6'd0); idle(1);
`ifdef HIT_SWIPE_EN
        chk("swipe_level", fifo_level, 1);
        chk("swipe_kind", hit_kind, 2);
        chk("swipe_zone", hit_zone, 10);
        pop_one();
`else
        chk("noswipe_level", fifo_level, 0);
`endif
        frame(1'b1, 6'd10, 6'd0); idle(1);
        frame(1'b1, 6'd10, 6'd0); idle(1);
        chk("move_hit_level", fifo_level, 1);
        chk("move_hit_zone", hit_zone, 10);
        chk("move_hit_kind", hit_kind, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
